// File: rtl/wb_arbiter_if.sv
// Bundle of the two producer request channels and the register-file write
// port of the writeback arbiter. The arbiter uses the slave view; the
// producers (or a testbench) use the master view.
interface wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;

  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;

  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        idle;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, idle
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two producers (A = ALU, B = multdiv) each feed a
// DEPTH-entry FIFO of {rd, data}; one entry per cycle is drained round-robin
// onto a registered register-file write port. Writes to register 0 are
// consumed but never enabled. DEPTH must be a power of two and at least 2.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input logic         clock,
  input logic         ctrl_reset,
  wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic [36:0]   memA [DEPTH];
  logic [36:0]   memB [DEPTH];
  logic [AW-1:0] wrPtrA_q, rdPtrA_q, wrPtrB_q, rdPtrB_q;
  logic [CW-1:0] cntA_q, cntA_d, cntB_q, cntB_d;
  logic          lastGrant_q, lastGrant_d;
  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;

  logic        readyA, readyB, emptyA, emptyB;
  logic        pushA, pushB, popA, popB;
  logic [36:0] headA, headB, head;

  assign readyA = (cntA_q < FULL_COUNT);
  assign readyB = (cntB_q < FULL_COUNT);
  assign emptyA = (cntA_q == '0);
  assign emptyB = (cntB_q == '0);
  assign pushA  = bus.a_valid & readyA & ~ctrl_reset;
  assign pushB  = bus.b_valid & readyB & ~ctrl_reset;
  assign popA   = ~emptyA & (emptyB | (lastGrant_q == GRANT_B));
  assign popB   = ~emptyB & ~popA;
  assign headA  = memA[rdPtrA_q];
  assign headB  = memB[rdPtrB_q];
  assign head   = popA ? headA : headB;

  // Next-state for occupancy, grant history and the write-port registers.
  always_comb begin
    cntA_d      = cntA_q;
    cntB_d      = cntB_q;
    lastGrant_d = lastGrant_q;
    we_d        = 1'b0;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    if (pushA && !popA) cntA_d = cntA_q + CW'(1);
    else if (!pushA && popA) cntA_d = cntA_q - CW'(1);
    if (pushB && !popB) cntB_d = cntB_q + CW'(1);
    else if (!pushB && popB) cntB_d = cntB_q - CW'(1);
    if (popA || popB) begin
      lastGrant_d = popA ? GRANT_A : GRANT_B;
      we_d        = (head[36:32] != 5'd0);
      wreg_d      = head[36:32];
      wdata_d     = head[31:0];
    end
  end

  // Control state and write port, cleared the moment reset asserts.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      wrPtrA_q    <= '0;
      rdPtrA_q    <= '0;
      wrPtrB_q    <= '0;
      rdPtrB_q    <= '0;
      cntA_q      <= '0;
      cntB_q      <= '0;
      lastGrant_q <= GRANT_B;
      we_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
    end else begin
      if (pushA) wrPtrA_q <= wrPtrA_q + AW'(1);
      if (popA)  rdPtrA_q <= rdPtrA_q + AW'(1);
      if (pushB) wrPtrB_q <= wrPtrB_q + AW'(1);
      if (popB)  rdPtrB_q <= rdPtrB_q + AW'(1);
      cntA_q      <= cntA_d;
      cntB_q      <= cntB_d;
      lastGrant_q <= lastGrant_d;
      we_q        <= we_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
    end
  end

  // FIFO storage needs no reset; pointers and counts define what is valid.
  always_ff @(posedge clock) begin
    if (pushA) memA[wrPtrA_q] <= {bus.a_rd, bus.a_data};
    if (pushB) memB[wrPtrB_q] <= {bus.b_rd, bus.b_data};
  end

  assign bus.a_ready          = readyA;
  assign bus.b_ready          = readyB;
  assign bus.ctrl_writeEnable = we_q;
  assign bus.ctrl_writeReg    = wreg_q;
  assign bus.data_writeReg    = wdata_q;
  assign bus.idle             = emptyA & emptyB & ~we_q;

endmodule
